ysyx_23060136_axi_rd_arbiter: RTL and testbench
===============================================

# ysyx_23060136_axi_rd_arbiter

Two-master AXI4 read-channel arbiter that shares the single core memory read port between the IFU (I-cache refill) and the LSU (D-cache refill / uncached load). It sits between the IFU/LSU `ARBITER_*` bundles and the core's external AXI master read port. It grants one requester at a time and holds the grant from AR acceptance through the final R beat (`rlast`), so bursts never interleave.

## Interface
Parameters
- none; widths fixed: addr 32, id 4, len 8, size 3, burst 2, data 64, resp 2

Ports
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ARBITER_IFU_arvalid/araddr/arid/arlen/arsize/arburst  in  1/32/4/8/3/2  IFU AR request
- ARBITER_IFU_arready  out  1  IFU AR accept
- ARBITER_IFU_rvalid/rresp/rdata/rlast/rid  out  1/2/64/1/4  IFU R beat
- ARBITER_IFU_rready  in  1  IFU R accept
- ARBITER_LSU_arvalid/araddr/arid/arlen/arsize/arburst  in  1/32/4/8/3/2  LSU AR request
- ARBITER_LSU_arready  out  1  LSU AR accept
- ARBITER_LSU_rvalid/rresp/rdata/rlast/rid  out  1/2/64/1/4  LSU R beat
- ARBITER_LSU_rready  in  1  LSU R accept
- io_master_arvalid/araddr/arid/arlen/arsize/arburst  out  1/32/4/8/3/2  downstream AR
- io_master_arready  in  1  downstream AR accept
- io_master_rvalid/rresp/rdata/rlast/rid  in  1/2/64/1/4  downstream R beat
- io_master_rready  out  1  downstream R accept

## Operation
- FSM states: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R (registered).
- IDLE: no outputs asserted. Arbitration evaluated on `arvalid` of both sides; winner state entered next cycle.
- Fixed priority (default): LSU wins when both request (LSU holds the older instruction; avoids a pipeline deadlock where MEM stalls on a refill).
- X_AR: `io_master_ar*` = X's AR fields; `io_master_arvalid` = X_arvalid; X_arready = `io_master_arready`. On handshake -> X_R.
- X_R: X_r* = `io_master_r*`; X_rvalid = `io_master_rvalid`; `io_master_rready` = X_rready. On `rvalid & rready & rlast` -> IDLE.
- Non-owner: arready = 0, rvalid = 0, rdata/rresp/rid/rlast = 0.
- `rresp` and `rid` forwarded unchanged; not checked (error detection lives in requester).
- Owner deasserting `arvalid` before handshake is an AXI violation; behaviour undefined, flagged by bench assertion.
- Requests arriving during a grant wait; no queueing beyond each requester's held `arvalid`.

## Timing
- Reset (rst=1 at posedge): state = IDLE, priority pointer = IFU-last-served; all outputs 0 from the following cycle; in-flight burst abandoned (downstream shares `rst`).
- Grant latency: 1 cycle from `arvalid` seen in IDLE to `io_master_arvalid`.
- AR and R paths purely combinational pass-through within owner states; zero added latency per beat.
- Turnaround: cycle after last-beat handshake is IDLE; next grant's AR at earliest 2 cycles after `rlast` handshake.
- No new grant issued in the same cycle as `rlast`.
- Single-beat (arlen=0) bursts: `rlast` on first beat, same rules.

## Configuration
- `YSYX_23060136_ARB_RR_EN` defined: round-robin; 1-bit pointer records last-served master, updated on `rlast` handshake; on simultaneous requests the other master wins. Pointer resets to IFU-last-served (LSU first).
- Undefined: fixed LSU-over-IFU priority; pointer logic absent.

## Test plan
- IFU alone, araddr=0x8000_0000, arlen=3: master arvalid 1 cycle after IFU arvalid; 4 beats routed to IFU, last with rlast; LSU rvalid stays 0; IDLE after beat 4.
- IFU and LSU request in same cycle (fixed priority): LSU araddr=0x8000_1000 issued first; IFU arready held 0 until LSU rlast handshake, then IFU AR issued 2 cycles later.
- Same simultaneous case with `YSYX_23060136_ARB_RR_EN`: first LSU, then IFU; repeat simultaneous requests -> grants alternate LSU, IFU, LSU, IFU.
- Backpressure: IFU rready toggled 0/1 per cycle, arlen=1: master rready mirrors IFU rready; no beat lost or duplicated; rdata 0x1122334455667788 delivered intact.
- rresp=2'b10, rid=4'h3 on LSU burst: forwarded unchanged to LSU only.
- rst asserted mid-burst (after beat 2 of 4): next cycle all outputs 0, state IDLE; a fresh IFU request is granted normally.

Source files
------------

// File: rtl/ysyx_23060136_axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter (IFU / LSU -> core read port).
// One requester owns the downstream read port from AR acceptance through
// the final R beat, so bursts never interleave.
// Build option: YSYX_23060136_ARB_RR_EN selects round-robin arbitration;
// when it is undefined, LSU has fixed priority over IFU.
module ysyx_23060136_axi_rd_arbiter (
  input  logic        clk,
  input  logic        rst,
  // IFU read request / response
  input  logic        ARBITER_IFU_arvalid,
  input  logic [31:0] ARBITER_IFU_araddr,
  input  logic [3:0]  ARBITER_IFU_arid,
  input  logic [7:0]  ARBITER_IFU_arlen,
  input  logic [2:0]  ARBITER_IFU_arsize,
  input  logic [1:0]  ARBITER_IFU_arburst,
  output logic        ARBITER_IFU_arready,
  output logic        ARBITER_IFU_rvalid,
  output logic [1:0]  ARBITER_IFU_rresp,
  output logic [63:0] ARBITER_IFU_rdata,
  output logic        ARBITER_IFU_rlast,
  output logic [3:0]  ARBITER_IFU_rid,
  input  logic        ARBITER_IFU_rready,
  // LSU read request / response
  input  logic        ARBITER_LSU_arvalid,
  input  logic [31:0] ARBITER_LSU_araddr,
  input  logic [3:0]  ARBITER_LSU_arid,
  input  logic [7:0]  ARBITER_LSU_arlen,
  input  logic [2:0]  ARBITER_LSU_arsize,
  input  logic [1:0]  ARBITER_LSU_arburst,
  output logic        ARBITER_LSU_arready,
  output logic        ARBITER_LSU_rvalid,
  output logic [1:0]  ARBITER_LSU_rresp,
  output logic [63:0] ARBITER_LSU_rdata,
  output logic        ARBITER_LSU_rlast,
  output logic [3:0]  ARBITER_LSU_rid,
  input  logic        ARBITER_LSU_rready,
  // Downstream core read port
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  input  logic        io_master_arready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [63:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic        io_master_rready
);

  typedef enum logic [2:0] {StIdle, StIfuAr, StIfuR, StLsuAr, StLsuR} state_e;

  state_e state_q, state_d;
  logic   ifu_wins_tie;
  logic   last_beat_hs;

  // Final beat of the granted burst is transferred this cycle.
  assign last_beat_hs = io_master_rvalid & io_master_rready & io_master_rlast;

`ifdef YSYX_23060136_ARB_RR_EN
  // 1 = LSU was served last, so IFU wins the next tie.
  logic lsu_last_q, lsu_last_d;

  assign ifu_wins_tie = lsu_last_q;

  // Record which master finished the most recent burst.
  always_comb begin
    lsu_last_d = lsu_last_q;
    if (last_beat_hs) begin
      lsu_last_d = (state_q == StLsuR);
    end
  end

  // Round-robin pointer register; resets so that LSU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_last_q <= 1'b0;
    end else begin
      lsu_last_q <= lsu_last_d;
    end
  end
`else
  // Fixed priority: LSU always wins a tie.
  assign ifu_wins_tie = 1'b0;
`endif

  // Grant state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and grant hold until the last beat of the burst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ARBITER_LSU_arvalid && !(ARBITER_IFU_arvalid && ifu_wins_tie)) begin
          state_d = StLsuAr;
        end else if (ARBITER_IFU_arvalid) begin
          state_d = StIfuAr;
        end
      end
      StIfuAr: if (ARBITER_IFU_arvalid && io_master_arready) state_d = StIfuR;
      StIfuR:  if (last_beat_hs) state_d = StIdle;
      StLsuAr: if (ARBITER_LSU_arvalid && io_master_arready) state_d = StLsuR;
      StLsuR:  if (last_beat_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Combinational routing of the owner's AR/R channels; everything else is 0.
  always_comb begin
    io_master_arvalid   = 1'b0;
    io_master_araddr    = '0;
    io_master_arid      = '0;
    io_master_arlen     = '0;
    io_master_arsize    = '0;
    io_master_arburst   = '0;
    io_master_rready    = 1'b0;
    ARBITER_IFU_arready = 1'b0;
    ARBITER_IFU_rvalid  = 1'b0;
    ARBITER_IFU_rresp   = '0;
    ARBITER_IFU_rdata   = '0;
    ARBITER_IFU_rlast   = 1'b0;
    ARBITER_IFU_rid     = '0;
    ARBITER_LSU_arready = 1'b0;
    ARBITER_LSU_rvalid  = 1'b0;
    ARBITER_LSU_rresp   = '0;
    ARBITER_LSU_rdata   = '0;
    ARBITER_LSU_rlast   = 1'b0;
    ARBITER_LSU_rid     = '0;
    unique case (state_q)
      StIfuAr: begin
        io_master_arvalid   = ARBITER_IFU_arvalid;
        io_master_araddr    = ARBITER_IFU_araddr;
        io_master_arid      = ARBITER_IFU_arid;
        io_master_arlen     = ARBITER_IFU_arlen;
        io_master_arsize    = ARBITER_IFU_arsize;
        io_master_arburst   = ARBITER_IFU_arburst;
        ARBITER_IFU_arready = io_master_arready;
      end
      StIfuR: begin
        ARBITER_IFU_rvalid = io_master_rvalid;
        ARBITER_IFU_rresp  = io_master_rresp;
        ARBITER_IFU_rdata  = io_master_rdata;
        ARBITER_IFU_rlast  = io_master_rlast;
        ARBITER_IFU_rid    = io_master_rid;
        io_master_rready   = ARBITER_IFU_rready;
      end
      StLsuAr: begin
        io_master_arvalid   = ARBITER_LSU_arvalid;
        io_master_araddr    = ARBITER_LSU_araddr;
        io_master_arid      = ARBITER_LSU_arid;
        io_master_arlen     = ARBITER_LSU_arlen;
        io_master_arsize    = ARBITER_LSU_arsize;
        io_master_arburst   = ARBITER_LSU_arburst;
        ARBITER_LSU_arready = io_master_arready;
      end
      StLsuR: begin
        ARBITER_LSU_rvalid = io_master_rvalid;
        ARBITER_LSU_rresp  = io_master_rresp;
        ARBITER_LSU_rdata  = io_master_rdata;
        ARBITER_LSU_rlast  = io_master_rlast;
        ARBITER_LSU_rid    = io_master_rid;
        io_master_rready   = ARBITER_LSU_rready;
      end
      StIdle:  ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060136_axi_rd_arbiter.sv
// Self-checking bench for ysyx_23060136_axi_rd_arbiter.
// A transaction-level model (owner + address-phase flag + tie pointer) predicts
// every output each cycle; directed tests add literal expectations.
module tb_ysyx_23060136_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ARBITER_IFU_arvalid, ARBITER_IFU_arready, ARBITER_IFU_rvalid;
  logic [31:0] ARBITER_IFU_araddr;
  logic [3:0]  ARBITER_IFU_arid, ARBITER_IFU_rid;
  logic [7:0]  ARBITER_IFU_arlen;
  logic [2:0]  ARBITER_IFU_arsize;
  logic [1:0]  ARBITER_IFU_arburst, ARBITER_IFU_rresp;
  logic [63:0] ARBITER_IFU_rdata;
  logic        ARBITER_IFU_rlast, ARBITER_IFU_rready;
  logic        ARBITER_LSU_arvalid, ARBITER_LSU_arready, ARBITER_LSU_rvalid;
  logic [31:0] ARBITER_LSU_araddr;
  logic [3:0]  ARBITER_LSU_arid, ARBITER_LSU_rid;
  logic [7:0]  ARBITER_LSU_arlen;
  logic [2:0]  ARBITER_LSU_arsize;
  logic [1:0]  ARBITER_LSU_arburst, ARBITER_LSU_rresp;
  logic [63:0] ARBITER_LSU_rdata;
  logic        ARBITER_LSU_rlast, ARBITER_LSU_rready;
  logic        io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid, io_master_rid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst, io_master_rresp;
  logic [63:0] io_master_rdata;
  logic        io_master_rlast;

  ysyx_23060136_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .ARBITER_IFU_arvalid(ARBITER_IFU_arvalid), .ARBITER_IFU_araddr(ARBITER_IFU_araddr),
    .ARBITER_IFU_arid(ARBITER_IFU_arid), .ARBITER_IFU_arlen(ARBITER_IFU_arlen),
    .ARBITER_IFU_arsize(ARBITER_IFU_arsize), .ARBITER_IFU_arburst(ARBITER_IFU_arburst),
    .ARBITER_IFU_arready(ARBITER_IFU_arready), .ARBITER_IFU_rvalid(ARBITER_IFU_rvalid),
    .ARBITER_IFU_rresp(ARBITER_IFU_rresp), .ARBITER_IFU_rdata(ARBITER_IFU_rdata),
    .ARBITER_IFU_rlast(ARBITER_IFU_rlast), .ARBITER_IFU_rid(ARBITER_IFU_rid),
    .ARBITER_IFU_rready(ARBITER_IFU_rready),
    .ARBITER_LSU_arvalid(ARBITER_LSU_arvalid), .ARBITER_LSU_araddr(ARBITER_LSU_araddr),
    .ARBITER_LSU_arid(ARBITER_LSU_arid), .ARBITER_LSU_arlen(ARBITER_LSU_arlen),
    .ARBITER_LSU_arsize(ARBITER_LSU_arsize), .ARBITER_LSU_arburst(ARBITER_LSU_arburst),
    .ARBITER_LSU_arready(ARBITER_LSU_arready), .ARBITER_LSU_rvalid(ARBITER_LSU_rvalid),
    .ARBITER_LSU_rresp(ARBITER_LSU_rresp), .ARBITER_LSU_rdata(ARBITER_LSU_rdata),
    .ARBITER_LSU_rlast(ARBITER_LSU_rlast), .ARBITER_LSU_rid(ARBITER_LSU_rid),
    .ARBITER_LSU_rready(ARBITER_LSU_rready),
    .io_master_arvalid(io_master_arvalid), .io_master_araddr(io_master_araddr),
    .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen),
    .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
    .io_master_arready(io_master_arready), .io_master_rvalid(io_master_rvalid),
    .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .io_master_rready(io_master_rready)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [7:0] len; logic [3:0] id;} req_t;
  typedef struct {logic [63:0] data; logic [1:0] resp; logic [3:0] id; logic last;} beat_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  req_t  ifu_q[$], lsu_q[$];
  beat_t ifu_beats[$], lsu_beats[$];
  logic [31:0] ar_addr_q[$];
  int    ar_cyc_q[$];
  int    ifu_last_cyc, lsu_last_cyc;
  int    ifu_ph = 0, lsu_ph = 0;  // 0 idle, 1 AR pending, 2 awaiting last beat
  bit    ifu_toggle = 1'b0;
  logic [63:0] slv_seed = 64'h0;
  logic [1:0]  slv_rresp = 2'b00;
  logic [3:0]  slv_rid = 4'h0;

  // Model state: current owner (0 none, 1 IFU, 2 LSU), address still open, tie pointer.
  int m_owner = 0;
  bit m_ar_open = 1'b0;
  bit m_lsu_last = 1'b0;
  bit model_ok = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input bit ifu_req, input bit lsu_req);
    if (ifu_req && lsu_req) begin
`ifdef YSYX_23060136_ARB_RR_EN
      return m_lsu_last ? 1 : 2;
`else
      return 2;
`endif
    end
    if (lsu_req) return 2;
    if (ifu_req) return 1;
    return 0;
  endfunction

  // IFU requester: holds arvalid until accepted, then waits for its last beat.
  initial begin : ifu_master
    bit ar_hs, last_hs, rst_s;
    req_t r;
    ARBITER_IFU_arvalid = 1'b0; ARBITER_IFU_araddr = '0; ARBITER_IFU_arid = '0;
    ARBITER_IFU_arlen = '0; ARBITER_IFU_arsize = 3'd3; ARBITER_IFU_arburst = 2'b01;
    ARBITER_IFU_rready = 1'b1;
    forever begin
      @(posedge clk);
      rst_s = rst;
      ar_hs = ARBITER_IFU_arvalid && ARBITER_IFU_arready;
      last_hs = ARBITER_IFU_rvalid && ARBITER_IFU_rready && ARBITER_IFU_rlast;
      #1;
      if (rst_s) begin
        ifu_ph = 0;
        ARBITER_IFU_arvalid = 1'b0;
      end else begin
        if (ifu_ph == 1 && ar_hs) begin
          ifu_ph = 2;
          ARBITER_IFU_arvalid = 1'b0;
        end else if (ifu_ph == 2 && last_hs) begin
          ifu_ph = 0;
        end
        if (ifu_ph == 0 && ifu_q.size() > 0) begin
          r = ifu_q.pop_front();
          ARBITER_IFU_araddr = r.addr; ARBITER_IFU_arlen = r.len; ARBITER_IFU_arid = r.id;
          ARBITER_IFU_arvalid = 1'b1;
          ifu_ph = 1;
        end
      end
      ARBITER_IFU_rready = ifu_toggle ? ~ARBITER_IFU_rready : 1'b1;
    end
  end

  // LSU requester: same protocol, always ready for R beats.
  initial begin : lsu_master
    bit ar_hs, last_hs, rst_s;
    req_t r;
    ARBITER_LSU_arvalid = 1'b0; ARBITER_LSU_araddr = '0; ARBITER_LSU_arid = '0;
    ARBITER_LSU_arlen = '0; ARBITER_LSU_arsize = 3'd2; ARBITER_LSU_arburst = 2'b01;
    ARBITER_LSU_rready = 1'b1;
    forever begin
      @(posedge clk);
      rst_s = rst;
      ar_hs = ARBITER_LSU_arvalid && ARBITER_LSU_arready;
      last_hs = ARBITER_LSU_rvalid && ARBITER_LSU_rready && ARBITER_LSU_rlast;
      #1;
      if (rst_s) begin
        lsu_ph = 0;
        ARBITER_LSU_arvalid = 1'b0;
      end else begin
        if (lsu_ph == 1 && ar_hs) begin
          lsu_ph = 2;
          ARBITER_LSU_arvalid = 1'b0;
        end else if (lsu_ph == 2 && last_hs) begin
          lsu_ph = 0;
        end
        if (lsu_ph == 0 && lsu_q.size() > 0) begin
          r = lsu_q.pop_front();
          ARBITER_LSU_araddr = r.addr; ARBITER_LSU_arlen = r.len; ARBITER_LSU_arid = r.id;
          ARBITER_LSU_arvalid = 1'b1;
          lsu_ph = 1;
        end
      end
    end
  end

  // Downstream memory: always accepts AR, returns seed+beat data one beat per ready cycle.
  initial begin : mem_slave
    bit ar_hs, r_hs, rst_s, active;
    int beat, len, new_len;
    active = 1'b0; beat = 0; len = 0;
    io_master_arready = 1'b1; io_master_rvalid = 1'b0; io_master_rresp = '0;
    io_master_rdata = '0; io_master_rlast = 1'b0; io_master_rid = '0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      ar_hs = io_master_arvalid && io_master_arready;
      r_hs = io_master_rvalid && io_master_rready;
      new_len = int'(io_master_arlen);
      #1;
      if (rst_s) begin
        active = 1'b0;
      end else begin
        if (r_hs && active) begin
          if (beat == len) active = 1'b0;
          else beat++;
        end
        if (ar_hs) begin
          active = 1'b1; beat = 0; len = new_len;
        end
      end
      io_master_rvalid = active;
      io_master_rdata  = active ? slv_seed + 64'(beat) : 64'h0;
      io_master_rlast  = active && (beat == len);
      io_master_rresp  = active ? slv_rresp : 2'b00;
      io_master_rid    = active ? slv_rid : 4'h0;
    end
  end

  // Records AR handshakes and delivered beats per requester.
  initial begin : monitor
    beat_t b;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        if (io_master_arvalid && io_master_arready) begin
          ar_addr_q.push_back(io_master_araddr);
          ar_cyc_q.push_back(cyc);
        end
        if (ARBITER_IFU_rvalid && ARBITER_IFU_rready) begin
          b.data = ARBITER_IFU_rdata; b.resp = ARBITER_IFU_rresp;
          b.id = ARBITER_IFU_rid; b.last = ARBITER_IFU_rlast;
          ifu_beats.push_back(b);
          if (ARBITER_IFU_rlast) ifu_last_cyc = cyc;
        end
        if (ARBITER_LSU_rvalid && ARBITER_LSU_rready) begin
          b.data = ARBITER_LSU_rdata; b.resp = ARBITER_LSU_rresp;
          b.id = ARBITER_LSU_rid; b.last = ARBITER_LSU_rlast;
          lsu_beats.push_back(b);
          if (ARBITER_LSU_rlast) lsu_last_cyc = cyc;
        end
      end
    end
  end

  // Model update: one grant at a time, address phase then data phase until last beat.
  initial begin : model
    bit own_arvalid, own_rready;
    forever begin
      @(posedge clk);
      own_arvalid = (m_owner == 1) ? ARBITER_IFU_arvalid : ARBITER_LSU_arvalid;
      own_rready  = (m_owner == 1) ? ARBITER_IFU_rready : ARBITER_LSU_rready;
      if (rst) begin
        m_owner = 0; m_ar_open = 1'b0; m_lsu_last = 1'b0; model_ok = 1'b1;
      end else if (model_ok) begin
        if (m_owner == 0) begin
          m_owner = pick(ARBITER_IFU_arvalid, ARBITER_LSU_arvalid);
          m_ar_open = (m_owner != 0);
        end else if (m_ar_open) begin
          assert (own_arvalid) else begin
            errors++;
            $display("FAIL arvalid_hold: owner %0d dropped arvalid before handshake", m_owner);
          end
          if (own_arvalid && io_master_arready) m_ar_open = 1'b0;
        end else if (io_master_rvalid && own_rready && io_master_rlast) begin
          m_lsu_last = (m_owner == 2);
          m_owner = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin : compare
    logic [50:0] em;
    logic [72:0] ei, el, rbus;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        em = '0; ei = '0; el = '0;
        rbus = {1'b0, io_master_rvalid, io_master_rresp, io_master_rdata, io_master_rlast,
                io_master_rid};
        if (m_owner == 1 && m_ar_open) begin
          em = {1'b0, ARBITER_IFU_arvalid, ARBITER_IFU_araddr, ARBITER_IFU_arid,
                ARBITER_IFU_arlen, ARBITER_IFU_arsize, ARBITER_IFU_arburst};
          ei[72] = io_master_arready;
        end else if (m_owner == 1) begin
          em[50] = ARBITER_IFU_rready;
          ei = rbus;
        end else if (m_owner == 2 && m_ar_open) begin
          em = {1'b0, ARBITER_LSU_arvalid, ARBITER_LSU_araddr, ARBITER_LSU_arid,
                ARBITER_LSU_arlen, ARBITER_LSU_arsize, ARBITER_LSU_arburst};
          el[72] = io_master_arready;
        end else if (m_owner == 2) begin
          em[50] = ARBITER_LSU_rready;
          el = rbus;
        end
        check("cyc_master", 128'({io_master_rready, io_master_arvalid, io_master_araddr,
              io_master_arid, io_master_arlen, io_master_arsize, io_master_arburst}), 128'(em));
        check("cyc_ifu", 128'({ARBITER_IFU_arready, ARBITER_IFU_rvalid, ARBITER_IFU_rresp,
              ARBITER_IFU_rdata, ARBITER_IFU_rlast, ARBITER_IFU_rid}), 128'(ei));
        check("cyc_lsu", 128'({ARBITER_LSU_arready, ARBITER_LSU_rvalid, ARBITER_LSU_rresp,
              ARBITER_LSU_rdata, ARBITER_LSU_rlast, ARBITER_LSU_rid}), 128'(el));
      end
    end
  end

  task automatic clear_logs();
    ifu_beats.delete(); lsu_beats.delete(); ar_addr_q.delete(); ar_cyc_q.delete();
  endtask

  task automatic push_ifu(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    req_t r;
    r.addr = a; r.len = l; r.id = id;
    ifu_q.push_back(r);
  endtask

  task automatic push_lsu(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    req_t r;
    r.addr = a; r.len = l; r.id = id;
    lsu_q.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((ifu_ph != 0 || lsu_ph != 0 || ifu_q.size() != 0 || lsu_q.size() != 0) && n < 500)
    begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for idle, got busy expected idle", name);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_master"}, 128'({io_master_arvalid, io_master_araddr, io_master_arlen,
          io_master_rready}), 128'h0);
    check({name, "_ifu"}, 128'({ARBITER_IFU_arready, ARBITER_IFU_rvalid, ARBITER_IFU_rresp,
          ARBITER_IFU_rdata, ARBITER_IFU_rlast, ARBITER_IFU_rid}), 128'h0);
    check({name, "_lsu"}, 128'({ARBITER_LSU_arready, ARBITER_LSU_rvalid, ARBITER_LSU_rresp,
          ARBITER_LSU_rdata, ARBITER_LSU_rlast, ARBITER_LSU_rid}), 128'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] exp_order [4];
    logic [3:0]  lasts;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // IFU alone, 4-beat burst.
    clear_logs();
    slv_seed = 64'hA000_0000_0000_0000;
    push_ifu(32'h8000_0000, 8'd3, 4'h1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ARBITER_IFU_arvalid && n < 20);
    check("t1_idle_same_cycle", 128'(io_master_arvalid), 128'h0);
    @(negedge clk);
    check("t1_grant", 128'({io_master_arvalid, io_master_araddr, io_master_arlen}),
          128'({1'b1, 32'h8000_0000, 8'd3}));
    wait_idle("t1");
    check("t1_ifu_beats", 128'(ifu_beats.size()), 128'd4);
    lasts = '0;
    foreach (ifu_beats[i]) if (i < 4) lasts[i] = ifu_beats[i].last;
    check("t1_rlast_pattern", 128'(lasts), 128'b1000);
    if (ifu_beats.size() == 4) begin
      check("t1_data0", 128'(ifu_beats[0].data), 128'(64'hA000_0000_0000_0000));
      check("t1_data3", 128'(ifu_beats[3].data), 128'(64'hA000_0000_0000_0003));
    end
    check("t1_lsu_beats", 128'(lsu_beats.size()), 128'd0);

    // Simultaneous requests: LSU first, IFU AR two cycles after LSU last beat.
    clear_logs();
    slv_seed = 64'hB000_0000_0000_0000;
    push_lsu(32'h8000_1000, 8'd1, 4'h2);
    push_ifu(32'h8000_0040, 8'd1, 4'h1);
    wait_idle("t2");
    check("t2_ar_count", 128'(ar_addr_q.size()), 128'd2);
    if (ar_addr_q.size() == 2) begin
      check("t2_first_lsu", 128'(ar_addr_q[0]), 128'h8000_1000);
      check("t2_second_ifu", 128'(ar_addr_q[1]), 128'h8000_0040);
      check("t2_turnaround", 128'(ar_cyc_q[1] - lsu_last_cyc), 128'd2);
    end
    check("t2_beats", 128'({16'(ifu_beats.size()), 16'(lsu_beats.size())}),
          128'({16'd2, 16'd2}));

    // Back-to-back contention: grant order depends on the arbitration mode.
    clear_logs();
    push_lsu(32'h8000_2000, 8'd0, 4'h4);
    push_lsu(32'h8000_2100, 8'd0, 4'h5);
    push_ifu(32'h8000_3000, 8'd0, 4'h6);
    push_ifu(32'h8000_3100, 8'd0, 4'h7);
`ifdef YSYX_23060136_ARB_RR_EN
    exp_order = '{32'h8000_2000, 32'h8000_3000, 32'h8000_2100, 32'h8000_3100};
`else
    exp_order = '{32'h8000_2000, 32'h8000_2100, 32'h8000_3000, 32'h8000_3100};
`endif
    wait_idle("t3");
    check("t3_ar_count", 128'(ar_addr_q.size()), 128'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ar_addr_q.size()) check("t3_order", 128'(ar_addr_q[i]), 128'(exp_order[i]));
    end

    // IFU backpressure on rready.
    clear_logs();
    slv_seed = 64'h1122_3344_5566_7788;
    ifu_toggle = 1'b1;
    push_ifu(32'h8000_0080, 8'd1, 4'h1);
    wait_idle("t4");
    ifu_toggle = 1'b0;
    check("t4_ifu_beats", 128'(ifu_beats.size()), 128'd2);
    if (ifu_beats.size() == 2) begin
      check("t4_data0", 128'(ifu_beats[0].data), 128'(64'h1122_3344_5566_7788));
      check("t4_data1", 128'(ifu_beats[1].data), 128'(64'h1122_3344_5566_7789));
      check("t4_last", 128'({ifu_beats[1].last, ifu_beats[0].last}), 128'b10);
    end

    // Response/id forwarded unchanged to LSU only.
    clear_logs();
    slv_rresp = 2'b10;
    slv_rid = 4'h3;
    push_lsu(32'h8000_4000, 8'd1, 4'h3);
    wait_idle("t5");
    slv_rresp = 2'b00;
    slv_rid = 4'h0;
    check("t5_lsu_beats", 128'(lsu_beats.size()), 128'd2);
    foreach (lsu_beats[i]) check("t5_resp_id", 128'({lsu_beats[i].resp, lsu_beats[i].id}),
                                 128'({2'b10, 4'h3}));
    check("t5_ifu_beats", 128'(ifu_beats.size()), 128'd0);

    // Reset after beat 2 of 4, then a fresh single-beat IFU request.
    clear_logs();
    push_ifu(32'h8000_0100, 8'd3, 4'h1);
    n = 0;
    while (ifu_beats.size() < 2 && n < 100) begin @(negedge clk); n++; end
    check("t6_two_beats_before_rst", 128'(ifu_beats.size()), 128'd2);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t6_after_rst");
    rst = 1'b0;
    clear_logs();
    slv_seed = 64'hC000_0000_0000_0000;
    push_ifu(32'h8000_0200, 8'd0, 4'h1);
    wait_idle("t6");
    check("t6_ar", 128'({16'(ar_addr_q.size()), ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'h0}),
          128'({16'd1, 32'h8000_0200}));
    check("t6_single_beat", 128'({16'(ifu_beats.size()),
          ifu_beats.size() > 0 ? ifu_beats[0].last : 1'b0}), 128'({16'd1, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
